// File: rtl/pb_debouncer.sv
// pb_debouncer: synchronise and debounce a raw push-button into a clean level for one_pulser.clkPB.
// Ports: clk (50 MHz), rst_n (async active-low), pb_raw (async bouncing pin),
//        pb_clean (debounced level, 1 = pressed), long_press (1-cycle hold pulse).
// Optional feature: define PB_LONG_PRESS_EN to build the long-press hold counter;
// otherwise long_press is tied to 0.
module pb_debouncer #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int CNT_WIDTH         = 26,
  parameter int ACTIVE_LOW_PB     = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic pb_clean,
  output logic long_press
);
  localparam logic INACTIVE = (ACTIVE_LOW_PB != 0);
  localparam longint CNT_CAP = longint'(1) << CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("pb_debouncer: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
    $error("pb_debouncer: DEBOUNCE_CYCLES must be at least 1");
  end
  if (longint'(DEBOUNCE_CYCLES) >= CNT_CAP || longint'(LONG_PRESS_CYCLES) >= CNT_CAP) begin : g_chk_w
    $error("pb_debouncer: CNT_WIDTH too small for DEBOUNCE_CYCLES/LONG_PRESS_CYCLES");
  end
  typedef enum logic [1:0] {S_RELEASED, S_PRESS_CHK, S_PRESSED, S_RELEASE_CHK} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_WIDTH-1:0] cnt, cnt_d, cnt_inc;
  logic pb_s;
  // Sync flops reset to the idle pin level so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= {SYNC_STAGES{INACTIVE}};
    else sync <= {sync[SYNC_STAGES-2:0], pb_raw};
  assign pb_s = sync[SYNC_STAGES-1] ^ INACTIVE;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      S_RELEASED:
        if (pb_s) begin
          state_d = S_PRESS_CHK;
          cnt_d = '0;
        end
      S_PRESS_CHK:
        if (!pb_s) state_d = S_RELEASED;
        else if (cnt == DB_LAST) begin
          state_d = S_PRESSED;
          cnt_d = '0;
        end else cnt_d = cnt_inc;
      S_PRESSED:
        if (!pb_s) begin
          state_d = S_RELEASE_CHK;
          cnt_d = '0;
        end
      S_RELEASE_CHK:
        if (pb_s) state_d = S_PRESSED;
        else if (cnt == DB_LAST) begin
          state_d = S_RELEASED;
          cnt_d = '0;
        end else cnt_d = cnt_inc;
      default: state_d = S_RELEASED;
    endcase
  end
  // pb_clean is registered from the next state so it is a bare flop output.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_RELEASED;
      cnt <= '0;
      pb_clean <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      pb_clean <= (state_d == S_PRESSED) || (state_d == S_RELEASE_CHK);
    end
`ifdef PB_LONG_PRESS_EN
  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_END = CNT_WIDTH'(LONG_PRESS_CYCLES);
  logic [CNT_WIDTH-1:0] hold;
  logic lp;
  // Hold time runs while pb_clean is high so a rejected release glitch does not
  // shift the pulse; parking at LP_END makes the pulse fire once per press.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold <= '0;
      lp <= 1'b0;
    end else begin
      lp <= pb_clean && (hold == LP_LAST);
      hold <= !pb_clean ? '0 : (hold == LP_END ? hold : hold + 1'b1);
    end
  assign long_press = lp;
`else
  assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_pb_debouncer.sv
// tb_pb_debouncer: directed scoreboard bench for pb_debouncer.
module tb_pb_debouncer;
  localparam int SYNC = 2;
  localparam int DB = 4;
  localparam int LP = 10;
  localparam int WIN = SYNC + DB + 1;
`ifdef PB_LONG_PRESS_EN
  localparam int LP_ON = 1;
`else
  localparam int LP_ON = 0;
`endif
  typedef struct packed {logic clean; logic lp;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pb_raw = 1'b0;
  logic pb_clean, long_press;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [WIN-1:0] sh = '0;
  logic m_clean = 1'b0;
  int t = 0;
  int rise_t = -1000;
  int lp_seen = 0;

  always #10 clk = ~clk;

  pb_debouncer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP),
    .CNT_WIDTH(26), .ACTIVE_LOW_PB(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb_raw(pb_raw), .pb_clean(pb_clean), .long_press(long_press)
  );

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b cycle=%0d", tag, obs, expv, t);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs == expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Window model: pb_clean flips once the DB+1 samples that reached the FSM
  // (sampled SYNC edges ago) all agree on the new level.
  task automatic model_edge(input logic v);
    logic prev;
    exp_t e;
    prev = m_clean;
    t++;
    if (!rst_n) begin
      sh = '0;
      m_clean = 1'b0;
      rise_t = -1000;
    end else begin
      sh = {sh[WIN-2:0], v};
      if (&sh[WIN-1:SYNC]) m_clean = 1'b1;
      else if (~|sh[WIN-1:SYNC]) m_clean = 1'b0;
      if (m_clean && !prev) rise_t = t;
    end
    e.clean = m_clean;
    e.lp = (LP_ON != 0) && rst_n && prev && (t - rise_t == LP);
    exp_q.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_int({tag, ".queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check_bit({tag, ".clean"}, pb_clean, e.clean);
    check_bit({tag, ".long_press"}, long_press, e.lp);
    if (long_press === 1'b1) lp_seen++;
  endtask

  task automatic cyc(input string tag, input logic v, input int n);
    repeat (n) begin
      pb_raw = v;
      @(posedge clk);
      model_edge(v);
      @(negedge clk);
      compare(tag);
    end
  endtask

  task automatic reset_now(input string tag);
    exp_t e;
    rst_n = 1'b0;
    #1;
    sh = '0;
    m_clean = 1'b0;
    rise_t = -1000;
    e.clean = 1'b0;
    e.lp = 1'b0;
    exp_q.push_back(e);
    compare(tag);
  endtask

  initial begin
    logic [11:0] bounce;
    bounce = 12'b0100_1011_1001;
    #1;
    reset_now("reset_initial");
    for (int i = 0; i < 3; i++) cyc("reset_toggle", i[0] ? 1'b0 : 1'b1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_reset_idle", 1'b0, 5);

    cyc("clean_press", 1'b1, 20);
    cyc("clean_release", 1'b0, 12);

    for (int i = 11; i >= 0; i--) cyc("bounce", bounce[i], 1);
    cyc("bounce_settle", 1'b1, 15);
    cyc("bounce_release", 1'b0, 12);

    cyc("glitch_press", 1'b1, 10);
    cyc("glitch_low", 1'b0, 2);
    lp_seen = 0;
    cyc("glitch_hold", 1'b1, 20);
    check_int("glitch_lp_pulses", lp_seen, LP_ON);
    cyc("glitch_release", 1'b0, 12);

    lp_seen = 0;
    cyc("long_hold", 1'b1, 30);
    cyc("long_release", 1'b0, 12);
    check_int("long_lp_pulses", lp_seen, LP_ON);
    lp_seen = 0;
    cyc("short_hold", 1'b1, 5);
    cyc("short_release", 1'b0, 12);
    check_int("short_lp_pulses", lp_seen, 0);
    cyc("too_short", 1'b1, 4);
    cyc("too_short_release", 1'b0, 8);

    cyc("midpress_hold", 1'b1, 10);
    check_bit("midpress_clean_before", pb_clean, 1'b1);
    reset_now("midpress_async");
    cyc("midpress_in_reset", 1'b1, 3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("midpress_requalify", 1'b1, 10);
    cyc("midpress_release", 1'b0, 12);

    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
